// File: rtl/vote_session_ctrl_pkg.sv
// Shared types and constants for the five-voter, three-candidate session controller.
package vote_session_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_TALLY,
    S_RESULT
  } state_e;

  localparam logic [2:0] CAND_A = 3'b001;
  localparam logic [2:0] CAND_B = 3'b010;
  localparam logic [2:0] CAND_C = 3'b100;

  localparam int NUM_VOTERS = 5;
  localparam int CNT_W      = 3;

  function automatic logic is_onehot(input logic [2:0] b);
    return (b == CAND_A) || (b == CAND_B) || (b == CAND_C);
  endfunction

endpackage

// File: rtl/vote_tally.sv
// Combinational ballot counter and winner picker; unused ballot slots hold 000.
module vote_tally
  import vote_session_ctrl_pkg::*;
(
  input  logic [NUM_VOTERS*3-1:0] ballots,
  output logic [2:0]              winner,
  output logic                    tie
);

  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;
  logic [CNT_W-1:0] top;
  logic [1:0]       n_top;

  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    cnt_c = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      cnt_a = cnt_a + CNT_W'(ballots[i*3]);
      cnt_b = cnt_b + CNT_W'(ballots[i*3+1]);
      cnt_c = cnt_c + CNT_W'(ballots[i*3+2]);
    end

    top = cnt_a;
    if (cnt_b > top) top = cnt_b;
    if (cnt_c > top) top = cnt_c;

    n_top = 2'(cnt_a == top) + 2'(cnt_b == top) + 2'(cnt_c == top);

    winner = 3'b000;
    tie    = 1'b0;
    // All-zero counts mean nobody voted: no winner and no tie.
    if (top != '0) begin
      if (n_top == 2'd1) begin
        if (cnt_a == top)      winner = CAND_A;
        else if (cnt_b == top) winner = CAND_B;
        else                   winner = CAND_C;
      end else begin
        tie = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session sequencer: opens a timed COLLECT window, latches one ballot per
// voter, tallies once, and holds the registered result until acknowledged.
module vote_session_ctrl
  import vote_session_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] vote_valid,
  input  logic [2:0] In_1,
  input  logic [2:0] In_2,
  input  logic [2:0] In_3,
  input  logic [2:0] In_4,
  input  logic [2:0] In_5,
  input  logic       result_ack,
  output logic       busy,
  output logic [4:0] voted,
  output logic [4:0] reject,
  output logic [2:0] Out,
  output logic       tie,
  output logic       result_valid
);

  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT);

  state_e                  state_q, state_d;
  logic [7:0]              timer_q, timer_d;
  logic [4:0]              voted_q, voted_d;
  logic [4:0]              reject_q, reject_d;
  logic [NUM_VOTERS*3-1:0] ballot_q, ballot_d;
  logic [2:0]              out_q, out_d;
  logic                    tie_q, tie_d;
  logic                    rv_q, rv_d;
  logic                    busy_q, busy_d;

  logic [NUM_VOTERS*3-1:0] ballot_in;
  logic [2:0]              tally_out;
  logic                    tally_tie;

  assign ballot_in = {In_5, In_4, In_3, In_2, In_1};

  vote_tally u_tally (
    .ballots (ballot_q),
    .winner  (tally_out),
    .tie     (tally_tie)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    voted_d  = voted_q;
    reject_d = '0;
    ballot_d = ballot_q;
    out_d    = out_q;
    tie_d    = tie_q;
    rv_d     = rv_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_COLLECT;
          timer_d  = TIMER_LOAD;
          voted_d  = '0;
          ballot_d = '0;
        end
      end

      S_COLLECT: begin
        for (int i = 0; i < NUM_VOTERS; i++) begin
          if (vote_valid[i]) begin
            if (is_onehot(ballot_in[i*3 +: 3]) && !voted_q[i]) begin
              ballot_d[i*3 +: 3] = ballot_in[i*3 +: 3];
              voted_d[i]         = 1'b1;
            end else begin
              reject_d[i] = 1'b1;
            end
          end
        end
        timer_d = timer_q - 8'd1;
        // timer_q == 1 marks the last COLLECT cycle; ballots in it are still taken.
        if (timer_q <= 8'd1 || voted_d == '1) begin
          state_d = S_TALLY;
          timer_d = '0;
        end
      end

      S_TALLY: begin
        out_d   = tally_out;
        tie_d   = tally_tie;
        rv_d    = 1'b1;
        state_d = S_RESULT;
      end

      S_RESULT: begin
        if (result_ack) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_COLLECT) || (state_d == S_TALLY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      voted_q  <= '0;
      reject_q <= '0;
      ballot_q <= '0;
      out_q    <= '0;
      tie_q    <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      voted_q  <= voted_d;
      reject_q <= reject_d;
      ballot_q <= ballot_d;
      out_q    <= out_d;
      tie_q    <= tie_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign voted        = voted_q;
  assign reject       = reject_q;
  assign Out          = out_q;
  assign tie          = tie_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench: one controller at the default window, one with a 4-cycle window.
module tb_vote_session_ctrl;

  logic       clk;
  logic       rst;
  logic       start, result_ack;
  logic [4:0] vote_valid;
  logic [2:0] in1, in2, in3, in4, in5;
  logic       busy, tie, rv;
  logic [4:0] voted, reject;
  logic [2:0] out;

  logic       start4, ack4;
  logic [4:0] vv4;
  logic [2:0] j1, j2, j3, j4, j5;
  logic       busy4, tie4, rv4;
  logic [4:0] voted4, reject4;
  logic [2:0] out4;

  int tests;
  int fails;

  vote_session_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid),
    .In_1(in1), .In_2(in2), .In_3(in3), .In_4(in4), .In_5(in5),
    .result_ack(result_ack), .busy(busy), .voted(voted), .reject(reject),
    .Out(out), .tie(tie), .result_valid(rv)
  );

  vote_session_ctrl #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .vote_valid(vv4),
    .In_1(j1), .In_2(j2), .In_3(j3), .In_4(j4), .In_5(j5),
    .result_ack(ack4), .busy(busy4), .voted(voted4), .reject(reject4),
    .Out(out4), .tie(tie4), .result_valid(rv4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ballots(input logic [2:0] a, b, c, d, e);
    in1 = a; in2 = b; in3 = c; in4 = d; in5 = e;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; start = 1'b0; result_ack = 1'b0; vote_valid = '0;
    ballots(3'b0, 3'b0, 3'b0, 3'b0, 3'b0);
    start4 = 1'b0; ack4 = 1'b0; vv4 = '0;
    j1 = '0; j2 = '0; j3 = '0; j4 = '0; j5 = '0;
    tick();
    tick();
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_voted", 8'(voted), 8'h00);
    check("rst_reject", 8'(reject), 8'h00);
    check("rst_out", 8'(out), 8'h0);
    check("rst_tie", 8'(tie), 8'h0);
    check("rst_rv", 8'(rv), 8'h0);
    rst = 1'b0;

    // Unanimous vote in a single cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("unan_busy_collect", 8'(busy), 8'h1);
    vote_valid = 5'b11111;
    ballots(3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
    tick();
    vote_valid = '0;
    check("unan_voted", 8'(voted), 8'h1f);
    check("unan_busy_tally", 8'(busy), 8'h1);
    check("unan_rv_tally", 8'(rv), 8'h0);
    tick();
    check("unan_rv", 8'(rv), 8'h1);
    check("unan_out", 8'(out), 8'h1);
    check("unan_tie", 8'(tie), 8'h0);
    check("unan_busy_result", 8'(busy), 8'h0);
    tick();
    check("unan_hold_rv", 8'(rv), 8'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_result_rv", 8'(rv), 8'h1);
    check("start_in_result_busy", 8'(busy), 8'h0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("unan_ack_rv", 8'(rv), 8'h0);
    check("unan_out_kept", 8'(out), 8'h1);

    // vote_valid in IDLE is ignored
    vote_valid = 5'b11111;
    ballots(3'b011, 3'b011, 3'b011, 3'b011, 3'b011);
    tick();
    vote_valid = '0;
    check("idle_reject", 8'(reject), 8'h00);
    check("idle_busy", 8'(busy), 8'h0);
    check("idle_voted", 8'(voted), 8'h1f);

    // Plurality tie, one ballot per cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    ballots(3'b100, 3'b100, 3'b010, 3'b010, 3'b001);
    for (int i = 0; i < 5; i++) begin
      vote_valid = 5'(1 << i);
      tick();
    end
    vote_valid = '0;
    check("plur_voted", 8'(voted), 8'h1f);
    check("plur_rv_tally", 8'(rv), 8'h0);
    tick();
    check("plur_rv", 8'(rv), 8'h1);
    check("plur_out", 8'(out), 8'h0);
    check("plur_tie", 8'(tie), 8'h1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;

    // Rejects: malformed ballot, then duplicate
    start = 1'b1;
    tick();
    start = 1'b0;
    ballots(3'b000, 3'b011, 3'b010, 3'b000, 3'b000);
    vote_valid = 5'b00010;
    tick();
    check("rej_bad_pulse", 8'(reject), 8'h02);
    check("rej_bad_voted", 8'(voted), 8'h00);
    vote_valid = 5'b00100;
    tick();
    check("rej_first_ok", 8'(reject), 8'h00);
    check("rej_first_voted", 8'(voted), 8'h04);
    tick();
    check("rej_dup_pulse", 8'(reject), 8'h04);
    check("rej_dup_voted", 8'(voted), 8'h04);
    vote_valid = '0;
    tick();
    check("rej_pulse_gone", 8'(reject), 8'h00);
    repeat (11) tick();
    check("rej_last_collect_rv", 8'(rv), 8'h0);
    check("rej_last_collect_busy", 8'(busy), 8'h1);
    tick();
    check("rej_tally_rv", 8'(rv), 8'h0);
    tick();
    check("rej_rv", 8'(rv), 8'h1);
    check("rej_out", 8'(out), 8'h2);
    check("rej_tie", 8'(tie), 8'h0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;

    // No votes: full timeout; ack during COLLECT must not matter
    start = 1'b1;
    tick();
    start = 1'b0;
    result_ack = 1'b1;
    repeat (5) tick();
    result_ack = 1'b0;
    check("none_busy_mid", 8'(busy), 8'h1);
    repeat (11) tick();
    check("none_tally_rv", 8'(rv), 8'h0);
    tick();
    check("none_rv", 8'(rv), 8'h1);
    check("none_out", 8'(out), 8'h0);
    check("none_tie", 8'(tie), 8'h0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;

    // Reset mid-session, with start asserted alongside reset
    start = 1'b1;
    tick();
    start = 1'b0;
    ballots(3'b001, 3'b010, 3'b000, 3'b000, 3'b000);
    vote_valid = 5'b00011;
    tick();
    vote_valid = '0;
    check("mid_voted", 8'(voted), 8'h03);
    rst = 1'b1;
    start = 1'b1;
    result_ack = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    result_ack = 1'b0;
    check("mid_rst_busy", 8'(busy), 8'h0);
    check("mid_rst_voted", 8'(voted), 8'h00);
    check("mid_rst_rv", 8'(rv), 8'h0);
    tick();
    check("mid_idle_busy", 8'(busy), 8'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clean_voted_cleared", 8'(voted), 8'h00);
    ballots(3'b001, 3'b001, 3'b010, 3'b100, 3'b001);
    vote_valid = 5'b11111;
    tick();
    vote_valid = '0;
    tick();
    check("clean_rv", 8'(rv), 8'h1);
    check("clean_out", 8'(out), 8'h1);
    check("clean_tie", 8'(tie), 8'h0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;

    // TIMEOUT=4: ballots in first and final COLLECT cycles
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    j1 = 3'b100;
    vv4 = 5'b00001;
    tick();
    vv4 = '0;
    tick();
    tick();
    check("t4_busy_c4", 8'(busy4), 8'h1);
    j2 = 3'b010;
    vv4 = 5'b00010;
    tick();
    vv4 = '0;
    check("t4_voted", 8'(voted4), 8'h03);
    check("t4_rv_tally", 8'(rv4), 8'h0);
    tick();
    check("t4_rv", 8'(rv4), 8'h1);
    check("t4_out", 8'(out4), 8'h0);
    check("t4_tie", 8'(tie4), 8'h1);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    check("t4_ack_rv", 8'(rv4), 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: COLLECT window length in clk cycles (range 1..255).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that opens a voting session.
REQ-005 SHALL have port vote_valid, input, 5: per-voter strobe; bit i qualifies In_(i+1).
REQ-006 SHALL have ports In_1..In_5, input, 3 each: one-hot candidate ballots (001, 010, 100).
REQ-007 SHALL have port result_ack, input, 1: consumer accepts the result.
REQ-008 SHALL have port busy, output, 1: high in COLLECT and TALLY.
REQ-009 SHALL have port voted, output, 5: bit i is set once voter i has a ballot accepted in the current session.
REQ-010 SHALL have port reject, output, 5: one-cycle pulse per rejected ballot.
REQ-011 SHALL have port Out, output, 3: registered one-hot winner, or 000 for no winner.
REQ-012 SHALL have port tie, output, 1: registered; set when two or more candidates share the top nonzero count.
REQ-013 SHALL have port result_valid, output, 1: Out and tie are valid.

Function
REQ-014 SHALL implement the FSM IDLE -> COLLECT -> TALLY -> RESULT -> IDLE.
REQ-015 IDLE: when start=1, SHALL enter COLLECT next cycle, load timer=TIMEOUT, clear voted and the ballot registers; start SHALL be ignored in every other state.
REQ-016 COLLECT: when vote_valid[i]=1, the ballot is one-hot and voted[i]=0, the ballot SHALL be latched and voted[i] set on the next edge.
REQ-017 COLLECT: a non-one-hot ballot (including 000), or any ballot with voted[i]=1, SHALL be discarded and SHALL pulse reject[i] for exactly one cycle on the next edge.
REQ-018 Any number of voters SHALL be accepted in the same cycle.
REQ-019 The timer SHALL decrement once per COLLECT cycle; COLLECT SHALL exit to TALLY when the timer reaches 1 or when all five voted bits would be set after the current edge, whichever comes first.
REQ-020 A ballot valid in the final COLLECT cycle SHALL be accepted.
REQ-021 vote_valid SHALL be ignored, with no reject, in IDLE, TALLY and RESULT.
REQ-022 Voters without an accepted ballot SHALL count as abstentions.
REQ-023 TALLY SHALL last one cycle and SHALL count ballots per candidate (3-bit counts, 0..5).
REQ-024 The winner SHALL be the candidate with the strictly highest count; a tie at the top or all-zero counts SHALL give Out=000; tie=1 only for a top-count tie with count>0.
REQ-025 Out and tie SHALL be registered at the TALLY->RESULT edge, and result_valid SHALL rise in that same cycle: latency is 1 cycle after COLLECT ends.
REQ-026 RESULT: result_valid, Out and tie SHALL hold until result_ack=1; on that edge the FSM SHALL return to IDLE with result_valid=0; Out and tie SHALL keep their values until the next TALLY.
REQ-027 result_ack outside RESULT SHALL have no effect.

Reset
REQ-028 rst=1 SHALL, at the next edge and from any state including mid-session, force IDLE with busy=0, voted=0, reject=0, Out=000, tie=0, result_valid=0, timer=0 and ballots cleared.
REQ-029 rst SHALL take priority over start, vote_valid and result_ack in the same cycle.

Structure
REQ-030 A shared package SHALL hold: the FSM state enum; the candidate one-hot constants CAND_A=001, CAND_B=010, CAND_C=100; NUM_VOTERS=5; and the count width 3.
REQ-031 Counting and winner selection SHALL live in one combinational sub-module, vote_tally (5 ballots in; Out and tie out), instantiated once.
REQ-032 The FSM, timer, voted mask and ballot registers SHALL remain in vote_session_ctrl.

Verification
REQ-033 Unanimous vote: start, then all five ballots = 001 in one cycle -> TALLY next cycle, Out=001, tie=0, result_valid held until result_ack.
REQ-034 Plurality with timeout: ballots 100, 100, 010, 010, 001 at one per cycle -> Out=000, tie=1. Separately, TIMEOUT=4 with only ballots 100 and 010 cast -> COLLECT ends after 4 cycles, Out=000, tie=1.
REQ-035 Rejects: In_2=011, then In_3=010 cast twice -> reject[1] pulses, then reject[2] pulses on the second ballot only; voted=00100.
REQ-036 No votes: start with no ballots before timeout -> Out=000, tie=0, result_valid=1.
REQ-037 Reset mid-session: rst asserted in COLLECT after two ballots -> next cycle IDLE, voted=0, busy=0; a subsequent start runs a clean session.
REQ-038 Ignored inputs: start asserted during RESULT, and vote_valid asserted in IDLE -> no state change and no reject.
